// File: rtl/msrh_rn_freelist_pkg.sv
// Configuration and rename-stage shared types for the physical-register free list.
// The commit reclaim message and the reset RNID layout live here, so rename-map reset can reuse them.
package msrh_conf_pkg;
  localparam int DISP_SIZE = 2;
endpackage

package msrh_pkg;
  import msrh_conf_pkg::*;

  localparam int FLIST_SIZE = 32;
  localparam int RNID_W     = 7;

  typedef struct packed {
    logic                                commit;
    logic [DISP_SIZE-1:0]                rnid_valid;
    logic [DISP_SIZE-1:0][RNID_W-1:0]    old_rnid;
    logic [DISP_SIZE-1:0][RNID_W-1:0]    rd_rnid;
    logic [DISP_SIZE-1:0]                dead_id;
    logic                                all_dead;
  } cmt_rnid_upd_t;

  // RNIDs 0..31 hold the initial architectural mapping, so free entries start above them.
  function automatic int freelist_init_rnid(input int bank, input int idx);
    return 32 + bank * FLIST_SIZE + idx;
  endfunction
endpackage

// File: rtl/msrh_rn_freelist_if.sv
// Allocation and reclaim bundle between rename/commit (master) and the free list (slave).
interface msrh_rn_freelist_if
  import msrh_pkg::*;
#(
  parameter int DISP_SIZE = msrh_conf_pkg::DISP_SIZE,
  parameter int RNID_W    = msrh_pkg::RNID_W,
  parameter int CNT_W     = $clog2(msrh_pkg::FLIST_SIZE) + 1
);
  logic [DISP_SIZE-1:0]               i_alloc_valid;
  logic [DISP_SIZE-1:0][RNID_W-1:0]   o_alloc_rnid;
  logic [DISP_SIZE-1:0]               o_empty;
  logic                               o_stall;
  logic [DISP_SIZE-1:0][CNT_W-1:0]    o_free_cnt;
  cmt_rnid_upd_t                      i_cmt_rnid_upd;
  logic                               o_err;

  modport master (
    output i_alloc_valid, i_cmt_rnid_upd,
    input  o_alloc_rnid, o_empty, o_stall, o_free_cnt, o_err
  );

  modport slave (
    input  i_alloc_valid, i_cmt_rnid_upd,
    output o_alloc_rnid, o_empty, o_stall, o_free_cnt, o_err
  );
endinterface

// File: rtl/msrh_rn_freelist_bank.sv
// One circular FIFO of free RNIDs; reset fills entry k with INIT_BASE + k.
// Error flag is sticky until reset and covers pops on empty and pushes on full without a pop.
module msrh_freelist_bank
  import msrh_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int WIDTH     = 7,
  parameter int INIT_BASE = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pop_req,
  input  logic                         push_req,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(SIZE):0]        count,
  output logic                         empty,
  output logic                         err
);
  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] mem_d [SIZE];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             full, do_pop, do_push;

  assign full  = (count_q == CNT_W'(SIZE));
  assign empty = (count_q == '0);

  // No write-to-read bypass: a pop on an empty bank is dropped even if a push lands this cycle.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_req & (~full | do_pop);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | (pop_req & empty) | (push_req & full & ~do_pop);
    if (do_push) begin
      mem_d[tail_q] = push_data;
      tail_d = (tail_q == PTR_W'(SIZE - 1)) ? '0 : tail_q + PTR_W'(1);
    end
    if (do_pop) begin
      head_d = (head_q == PTR_W'(SIZE - 1)) ? '0 : head_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SIZE; k++) begin
        mem_q[k] <= WIDTH'(INIT_BASE + k);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(SIZE);
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;
  assign err       = err_q;
endmodule

// File: rtl/msrh_rn_freelist.sv
// Rename-stage free list: one bank per dispatch slot, refilled from commit reclaim messages.
// Dead (squashed) commits return their own rd_rnid; live commits return the displaced old_rnid.
module msrh_rn_freelist
  import msrh_pkg::*;
#(
  parameter int DISP_SIZE  = msrh_conf_pkg::DISP_SIZE,
  parameter int FLIST_SIZE = msrh_pkg::FLIST_SIZE,
  parameter int RNID_W     = msrh_pkg::RNID_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  msrh_rn_freelist_if.slave    fl_if
);
  logic [DISP_SIZE-1:0]             push_valid;
  logic [DISP_SIZE-1:0][RNID_W-1:0] push_rnid;
  logic [DISP_SIZE-1:0]             bank_err;

  always_comb begin
    push_valid = '0;
    push_rnid  = '0;
    for (int d = 0; d < DISP_SIZE; d++) begin
      push_valid[d] = fl_if.i_cmt_rnid_upd.commit & fl_if.i_cmt_rnid_upd.rnid_valid[d];
      push_rnid[d]  = (fl_if.i_cmt_rnid_upd.dead_id[d] | fl_if.i_cmt_rnid_upd.all_dead) ?
                      fl_if.i_cmt_rnid_upd.rd_rnid[d] : fl_if.i_cmt_rnid_upd.old_rnid[d];
    end
  end

  for (genvar d = 0; d < DISP_SIZE; d++) begin : g_bank
    msrh_freelist_bank #(
      .SIZE      (FLIST_SIZE),
      .WIDTH     (RNID_W),
      .INIT_BASE (freelist_init_rnid(d, 0))
    ) u_bank (
      .clk       (i_clk),
      .rst       (i_reset),
      .pop_req   (fl_if.i_alloc_valid[d]),
      .push_req  (push_valid[d]),
      .push_data (push_rnid[d]),
      .head_data (fl_if.o_alloc_rnid[d]),
      .count     (fl_if.o_free_cnt[d]),
      .empty     (fl_if.o_empty[d]),
      .err       (bank_err[d])
    );
  end

  assign fl_if.o_stall = |fl_if.o_empty;
  assign fl_if.o_err   = |bank_err;
endmodule
